reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
- REQ-001: Parameters SHALL be, one per line:
  - DATA_W, default 32, write-data width.
  - ADDR_W, default 5, register-address width.
  - DEPTH, default 2, per-requester queue depth (power of two, at least 2).
- REQ-002: Clk  in  1  single clock; all state updates on posedge Clk.
- REQ-003: Rst_n  in  1  reset; synchronous, active-low.
- REQ-004: Req0_valid  in  1  requester 0 (ALU writeback) has a write.
- REQ-005: Req0_ready  out  1  requester 0 queue can accept.
- REQ-006: Req0_reg  in  ADDR_W  requester 0 destination register.
- REQ-007: Req0_data  in  DATA_W  requester 0 write data.
- REQ-008: Req1_valid, Req1_ready, Req1_reg, Req1_data SHALL mirror REQ-004..007 for requester 1 (memory/load writeback).
- REQ-009: Reg_write  out  1  register-file write enable.
- REQ-010: Write_reg  out  ADDR_W  register-file write address.
- REQ-011: Write_data  out  DATA_W  register-file write data.
- REQ-012: Grant  out  2  one-hot; marks the requester whose entry was popped at the last edge; 00 if none was popped.
- REQ-013: Idle  out  1  both queues empty and Reg_write low.

Function
- REQ-014: A transfer on requester n SHALL occur at a posedge where Reqn_valid=1 and Reqn_ready=1; {reg, data} is pushed into queue n.
- REQ-015: Reqn_ready SHALL be 1 iff queue n occupancy is below DEPTH, computed from the registered count. A full queue refuses a push even when it pops at the same edge.
- REQ-016: Each queue SHALL be FIFO-ordered. Simultaneous push and pop on a non-full queue SHALL leave the count unchanged.
- REQ-017: At each posedge, if at least one queue is non-empty, exactly one head SHALL be popped:
  - only one queue non-empty: pop that queue;
  - both non-empty: pop the requester not granted last (Last_grant pointer);
  - after the pop, Last_grant takes the popped index.
- REQ-018: A popped entry with nonzero reg SHALL drive Reg_write=1, Write_reg=reg and Write_data=data, registered, for exactly the cycle following the pop edge.
- REQ-019: A popped entry with reg=0 SHALL be discarded. Reg_write SHALL be 0 in the following cycle, while Grant still marks the popped requester.
- REQ-020: When no queue is non-empty at an edge, the following cycle SHALL have Reg_write=0, Grant=00, and Write_reg/Write_data holding their previous values.
- REQ-021: Latency: a transfer accepted into an empty queue at edge k, with no contention, SHALL appear on the write port in the cycle after edge k+1.
- REQ-022: Throughput SHALL be one write per cycle sustained. No entry SHALL wait more than 2*DEPTH pops.
- REQ-023: Two entries for the same register from different requesters SHALL be written in arbitration order. Requesters own ordering between themselves.

Reset
- REQ-024: With Rst_n=0 at a posedge, the following state SHALL be cleared:
  - both queues empty;
  - Reg_write=0, Grant=00, Write_reg=0, Write_data=0;
  - Last_grant=1, so requester 0 wins the first contention;
  - Idle=1 and Req0_ready=Req1_ready=1 in the following cycle.
- REQ-025: Reset asserted mid-operation SHALL discard all queued entries, and no write SHALL issue in the cycle after the reset edge.

Configuration
- REQ-026: With macro WB_FWD_EN defined, the block SHALL add the following ports:
  - inputs Read_reg1 and Read_reg2 (ADDR_W each);
  - outputs Fwd_hit1, Fwd_hit2 (1 bit each) and Fwd_data1, Fwd_data2 (DATA_W each).
- REQ-027: With WB_FWD_EN defined, Fwd_hitN SHALL equal combinationally (Reg_write and Write_reg==Read_regN and Read_regN!=0). Fwd_dataN SHALL equal Write_data when Fwd_hitN=1, else 0.
- REQ-028: Without WB_FWD_EN, those ports and that logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-029: Package wb_arb_pkg SHALL hold the DATA_W/ADDR_W defaults and the typedef wb_entry_t {reg, data}.
- REQ-030: Sub-module wb_fifo SHALL provide one parameterized queue, instantiated twice. The arbiter and output registers SHALL live in reg_wb_arbiter.

Verification
- REQ-031: Reset then idle: Rst_n low 2 cycles, then high -> Idle=1, Req0_ready=Req1_ready=1, Reg_write=0.
- REQ-032: Single write: Req0 {reg=5, data=0xDEADBEEF} accepted at edge k -> Reg_write=1, Write_reg=5, Write_data=0xDEADBEEF in the cycle after edge k+1; Grant=01.
- REQ-033: Contention: both requesters hold 3 entries each (reg 1..3 / reg 9..11) -> write order 1,9,2,10,3,11 and Grant alternates 01,10. A queue with DEPTH=2 shows ready=0 while full.
- REQ-034: Zero register: Req1 {reg=0, data=0x1234} -> Grant=10 with Reg_write=0; the next queued entry issues the cycle after.
- REQ-035: Reset mid-burst: 2 entries queued, Rst_n low at the next edge -> no Reg_write follows, Idle=1, and the first contention after reset grants requester 0.
- REQ-036: WB_FWD_EN build: Read_reg1=7 while Write_reg=7 and Reg_write=1 -> Fwd_hit1=1 and Fwd_data1=Write_data; Read_reg2=0 -> Fwd_hit2=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   WB_DATA_W / WB_ADDR_W : default write-data and register-address widths.
//   wb_entry_t            : one queued writeback {register index, data}. The
//                           register field is named rd because "reg" is a
//                           keyword. Queues store the same layout as a flat
//                           vector {rd, data} so the widths can follow the
//                           top-level parameters.
package wb_arb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO used as one requester's writeback queue.
//   Clk, Rst_n : clock, synchronous active-low reset (empties the queue)
//   push, din  : write an entry (caller guarantees !full)
//   pop, dout  : dout shows the head; pop removes it (caller guarantees !empty)
//   full/empty : derived from the registered occupancy count
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   cnt;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter.
// Requester 0 (ALU) and requester 1 (load) each feed a DEPTH-entry queue; one
// head is popped per cycle (round-robin on contention) and drives a registered
// register-file write port. Entries targeting register 0 are dropped.
// Ports:
//   Clk, Rst_n                  : clock, synchronous active-low reset
//   ReqN_valid/ready/reg/data   : requester N push interface (N = 0, 1)
//   Reg_write/Write_reg/Write_data : registered write port
//   Grant                       : one-hot requester popped at the last edge
//   Idle                        : both queues empty and no write in flight
// Optional build macro WB_FWD_EN adds Read_reg1/2 inputs and
// Fwd_hit1/2, Fwd_data1/2 outputs that forward the current write.
module reg_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0_valid,
    output logic              Req0_ready,
    input  logic [ADDR_W-1:0] Req0_reg,
    input  logic [DATA_W-1:0] Req0_data,
    input  logic              Req1_valid,
    output logic              Req1_ready,
    input  logic [ADDR_W-1:0] Req1_reg,
    input  logic [DATA_W-1:0] Req1_data,
    output logic              Reg_write,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    output logic [1:0]        Grant,
    output logic              Idle
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] Read_reg1,
    input  logic [ADDR_W-1:0] Read_reg2,
    output logic              Fwd_hit1,
    output logic              Fwd_hit2,
    output logic [DATA_W-1:0] Fwd_data1,
    output logic [DATA_W-1:0] Fwd_data2
`endif
);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] head0, head1, head;
    logic               full0, full1, empty0, empty1;
    logic               push0, push1, pop0, pop1;
    logic               last_grant;   // 1: requester 1 was served last
    logic [ADDR_W-1:0]  head_reg;
    logic [DATA_W-1:0]  head_data;

    assign Req0_ready = !full0;
    assign Req1_ready = !full1;
    assign push0      = Req0_valid && Req0_ready;
    assign push1      = Req1_valid && Req1_ready;

    // On contention the requester not served last wins; otherwise whichever
    // queue holds something is popped.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (!empty0 && !empty1) begin
            pop0 = last_grant;
            pop1 = !last_grant;
        end else begin
            pop0 = !empty0;
            pop1 = !empty1;
        end
    end

    assign head      = pop1 ? head1 : head0;
    assign head_reg  = head[ENTRY_W-1 -: ADDR_W];
    assign head_data = head[DATA_W-1:0];

    wb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo0 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (push0),
        .din   ({Req0_reg, Req0_data}),
        .pop   (pop0),
        .dout  (head0),
        .full  (full0),
        .empty (empty0)
    );

    wb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (push1),
        .din   ({Req1_reg, Req1_data}),
        .pop   (pop1),
        .dout  (head1),
        .full  (full1),
        .empty (empty1)
    );

    // Write address/data only move on a real write, so they hold across
    // idle cycles and dropped register-0 entries.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Reg_write  <= 1'b0;
            Grant      <= 2'b00;
            Write_reg  <= '0;
            Write_data <= '0;
            last_grant <= 1'b1;
        end else begin
            Grant     <= {pop1, pop0};
            Reg_write <= (pop0 || pop1) && (head_reg != '0);
            if (pop0 || pop1) begin
                last_grant <= pop1;
                if (head_reg != '0) begin
                    Write_reg  <= head_reg;
                    Write_data <= head_data;
                end
            end
        end
    end

    assign Idle = empty0 && empty1 && !Reg_write;

`ifdef WB_FWD_EN
    assign Fwd_hit1  = Reg_write && (Write_reg == Read_reg1) && (Read_reg1 != '0);
    assign Fwd_hit2  = Reg_write && (Write_reg == Read_reg2) && (Read_reg2 != '0);
    assign Fwd_data1 = Fwd_hit1 ? Write_data : '0;
    assign Fwd_data2 = Fwd_hit2 ? Write_data : '0;
`endif

endmodule
